cpu_memory_stage: RTL and testbench

// - Pipeline stage directly downstream of execute. Consumes execute's tagged result (rd, pc_next, mem request fields).
// - Performs the data-bus load/store: byte lanes, sign/zero extension, misaligned split into two word accesses.
// - Hands tagged result to writeback; non-memory instructions pass through in 1 cycle.

---
 rtl/cpu_memory_pkg.sv | 34 +++
 rtl/cpu_memory_align.sv | 45 ++++
 rtl/cpu_memory_stage.sv | 164 ++++++++++++++++
 tb/tb_cpu_memory_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_memory_pkg.sv
// Shared definitions for the memory pipeline stage: FSM encodings, access-width
// codes, tag width and byte-lane mask helpers.
package cpu_memory_pkg;

  localparam int TAG_SIZE = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC0 = 2'd1;
  localparam logic [1:0] ST_ACC1 = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] WIDTH_BYTE = 3'd1;
  localparam logic [2:0] WIDTH_HALF = 3'd2;
  localparam logic [2:0] WIDTH_WORD = 3'd4;

  function automatic logic is_mem_width(input logic [2:0] width);
    return (width == WIDTH_BYTE) || (width == WIDTH_HALF) || (width == WIDTH_WORD);
  endfunction

  function automatic logic [3:0] base_mask(input logic [2:0] width);
    case (width)
      WIDTH_BYTE: return 4'b0001;
      WIDTH_HALF: return 4'b0011;
      WIDTH_WORD: return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

  // Low nibble: lanes of the first word; high nibble: spill into the next word.
  function automatic logic [7:0] lane_mask(input logic [2:0] width, input logic [1:0] offset);
    return {4'b0000, base_mask(width)} << offset;
  endfunction

endpackage

// File: rtl/cpu_memory_align.sv
// Combinational data-path for the memory stage: lane enables, store-data
// shifting, load-data merging across two words and zero/sign extension.
module cpu_memory_align
  import cpu_memory_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  width,
  input  logic        is_signed,
  input  logic        phase,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  input  logic [31:0] partial,
  output logic [3:0]  byte_enable,
  output logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0] lanes;
  logic [4:0] lo_shift;
  logic [5:0] hi_shift;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    lanes    = lane_mask(width, offset);
    lo_shift = {offset, 3'b000};
    hi_shift = 6'd32 - {1'b0, lo_shift};
    if (phase) begin
      byte_enable = lanes[7:4];
      wdata       = store_data >> hi_shift;
      merged      = partial | (bus_rdata << hi_shift);
    end else begin
      byte_enable = lanes[3:0];
      wdata       = store_data << lo_shift;
      merged      = bus_rdata >> lo_shift;
    end
    case (width)
      WIDTH_BYTE: load_data = {{24{is_signed & merged[7]}}, merged[7:0]};
      WIDTH_HALF: load_data = {{16{is_signed & merged[15]}}, merged[15:0]};
      default:    load_data = merged;
    endcase
  end

endmodule

// File: rtl/cpu_memory_stage.sv
// Memory pipeline stage: accepts a tagged result from execute, performs the
// data-bus load/store (optionally split across two words) and hands it to writeback.
module cpu_memory_stage
  import cpu_memory_pkg::*;
#(
  parameter bit          SPLIT_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES   = 0
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_stall,
  input  logic [TAG_SIZE-1:0] i_tag,
  input  logic [4:0]          i_inst_rd,
  input  logic [31:0]         i_rd,
  input  logic [31:0]         i_pc_next,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [2:0]          i_mem_width,
  input  logic                i_mem_signed,
  input  logic [31:0]         i_mem_address,
  output logic [TAG_SIZE-1:0] o_tag,
  output logic [4:0]          o_inst_rd,
  output logic [31:0]         o_rd,
  output logic [31:0]         o_pc_next,
  output logic                o_fault,
  output logic                o_stall,
  output logic                o_bus_request,
  output logic                o_bus_rw,
  output logic [31:0]         o_bus_address,
  output logic [3:0]          o_bus_byte_enable,
  output logic [31:0]         o_bus_wdata,
  input  logic [31:0]         i_bus_rdata,
  input  logic                i_bus_ready
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]          state;
  logic [15:0]         wait_count;
  logic [TAG_SIZE-1:0] tag_q;
  logic [4:0]          inst_rd_q;
  logic [31:0]         pc_next_q, addr_q, data_q, partial_q, result_q;
  logic [2:0]          width_q;
  logic                signed_q, write_q, split_q, fault_q;

  logic        accept, is_mem, misaligned, needs_split, bus_done, timed_out;
  logic [3:0]  align_be;
  logic [31:0] align_wdata, merged, load_data;

  assign accept = (state == ST_IDLE) && !i_stall && (i_tag != o_tag);
  assign is_mem = (i_mem_read || i_mem_write) && is_mem_width(i_mem_width);

  // Misaligned (fault criterion) is wider than "crosses a word" (split criterion).
  assign misaligned  = ((i_mem_width == WIDTH_HALF) && i_mem_address[0]) ||
                       ((i_mem_width == WIDTH_WORD) && (i_mem_address[1:0] != 2'b00));
  assign needs_split = ((i_mem_width == WIDTH_HALF) && (i_mem_address[1:0] == 2'b11)) ||
                       ((i_mem_width == WIDTH_WORD) && (i_mem_address[1:0] != 2'b00));

  assign o_bus_request = (state == ST_ACC0) || (state == ST_ACC1);
  assign bus_done      = o_bus_request && i_bus_ready;
  assign timed_out     = (TIMEOUT_CYCLES != 0) && o_bus_request && !i_bus_ready &&
                         (wait_count == TIMEOUT_LAST);
  assign o_stall       = (i_tag != o_tag) && (state != ST_IDLE);

  assign o_bus_rw          = o_bus_request && write_q;
  assign o_bus_address     = o_bus_request ?
                             {addr_q[31:2] + {29'd0, state == ST_ACC1}, 2'b00} : 32'd0;
  assign o_bus_byte_enable = o_bus_request ? align_be : 4'd0;
  assign o_bus_wdata       = o_bus_request ? align_wdata : 32'd0;

  cpu_memory_align u_align (
    .offset      (addr_q[1:0]),
    .width       (width_q),
    .is_signed   (signed_q),
    .phase       (state == ST_ACC1),
    .store_data  (data_q),
    .bus_rdata   (i_bus_rdata),
    .partial     (partial_q),
    .byte_enable (align_be),
    .wdata       (align_wdata),
    .merged      (merged),
    .load_data   (load_data)
  );

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      wait_count <= '0;
      tag_q      <= '0;
      inst_rd_q  <= '0;
      pc_next_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      partial_q  <= '0;
      result_q   <= '0;
      width_q    <= '0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      split_q    <= 1'b0;
      fault_q    <= 1'b0;
      o_tag      <= '0;
      o_inst_rd  <= '0;
      o_rd       <= '0;
      o_pc_next  <= '0;
      o_fault    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mem && !(misaligned && !SPLIT_MISALIGNED)) begin
              state      <= ST_ACC0;
              wait_count <= '0;
              tag_q      <= i_tag;
              inst_rd_q  <= i_inst_rd;
              pc_next_q  <= i_pc_next;
              addr_q     <= i_mem_address;
              data_q     <= i_rd;
              width_q    <= i_mem_width;
              signed_q   <= i_mem_signed;
              write_q    <= i_mem_write;
              split_q    <= needs_split;
              fault_q    <= 1'b0;
            end else begin
              // Pass-through, or a misaligned access rejected without touching the bus.
              o_tag     <= i_tag;
              o_inst_rd <= i_inst_rd;
              o_pc_next <= i_pc_next;
              o_fault   <= is_mem;
              o_rd      <= is_mem ? 32'd0 : i_rd;
            end
          end
        end
        ST_ACC0, ST_ACC1: begin
          if (bus_done) begin
            wait_count <= '0;
            if ((state == ST_ACC0) && split_q) begin
              partial_q <= merged;
              state     <= ST_ACC1;
            end else begin
              result_q <= load_data;
              state    <= ST_DONE;
            end
          end else if (timed_out) begin
            fault_q <= 1'b1;
            state   <= ST_DONE;
          end else begin
            wait_count <= wait_count + 16'd1;
          end
        end
        default: begin
          o_tag     <= tag_q;
          o_inst_rd <= inst_rd_q;
          o_pc_next <= pc_next_q;
          o_fault   <= fault_q;
          o_rd      <= fault_q ? 32'd0 : (write_q ? data_q : result_q);
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_memory_stage.sv
// Directed bench for cpu_memory_stage: a vector table of single-access and
// pass-through instructions, plus hand sequences for split, stall, reset and timeout.
module tb_cpu_memory_stage;
  import cpu_memory_pkg::*;

  logic                i_clock = 1'b0;
  logic                i_reset;
  logic                i_stall;
  logic [TAG_SIZE-1:0] i_tag;
  logic [4:0]          i_inst_rd;
  logic [31:0]         i_rd, i_pc_next, i_mem_address, i_bus_rdata;
  logic                i_mem_read, i_mem_write, i_mem_signed, i_bus_ready;
  logic [2:0]          i_mem_width;

  logic [TAG_SIZE-1:0] o_tag, n_tag;
  logic [4:0]          o_inst_rd, n_inst_rd;
  logic [31:0]         o_rd, o_pc_next, o_bus_address, o_bus_wdata;
  logic [31:0]         n_rd, n_pc_next, n_bus_address, n_bus_wdata;
  logic                o_fault, o_stall, o_bus_request, o_bus_rw;
  logic                n_fault, n_stall, n_bus_request, n_bus_rw;
  logic [3:0]          o_bus_byte_enable, n_bus_byte_enable;

  int checks = 0;
  int errors = 0;

  always #5 i_clock = ~i_clock;

  cpu_memory_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_stall(i_stall), .i_tag(i_tag),
    .i_inst_rd(i_inst_rd), .i_rd(i_rd), .i_pc_next(i_pc_next),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_width(i_mem_width),
    .i_mem_signed(i_mem_signed), .i_mem_address(i_mem_address),
    .o_tag(o_tag), .o_inst_rd(o_inst_rd), .o_rd(o_rd), .o_pc_next(o_pc_next),
    .o_fault(o_fault), .o_stall(o_stall), .o_bus_request(o_bus_request),
    .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address),
    .o_bus_byte_enable(o_bus_byte_enable), .o_bus_wdata(o_bus_wdata),
    .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready)
  );

  cpu_memory_stage #(.SPLIT_MISALIGNED(1'b0), .TIMEOUT_CYCLES(4)) dut_ns (
    .i_clock(i_clock), .i_reset(i_reset), .i_stall(i_stall), .i_tag(i_tag),
    .i_inst_rd(i_inst_rd), .i_rd(i_rd), .i_pc_next(i_pc_next),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_width(i_mem_width),
    .i_mem_signed(i_mem_signed), .i_mem_address(i_mem_address),
    .o_tag(n_tag), .o_inst_rd(n_inst_rd), .o_rd(n_rd), .o_pc_next(n_pc_next),
    .o_fault(n_fault), .o_stall(n_stall), .o_bus_request(n_bus_request),
    .o_bus_rw(n_bus_rw), .o_bus_address(n_bus_address),
    .o_bus_byte_enable(n_bus_byte_enable), .o_bus_wdata(n_bus_wdata),
    .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready)
  );

  typedef struct {
    logic [3:0]  tag;
    logic        is_mem;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  width;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] rd;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] tag, input logic rd_en, input logic wr_en,
                       input logic [2:0] width, input logic sgn, input logic [31:0] addr,
                       input logic [31:0] rd);
    i_tag         = tag;
    i_inst_rd     = 5'(tag) + 5'd3;
    i_pc_next     = 32'h1000 + {28'd0, tag} * 4;
    i_mem_read    = rd_en;
    i_mem_write   = wr_en;
    i_mem_width   = width;
    i_mem_signed  = sgn;
    i_mem_address = addr;
    i_rd          = rd;
    i_bus_ready   = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [3:0] tag, input logic [31:0] exp_rd);
    check({name, "_tag"}, 32'(o_tag), 32'(tag));
    check({name, "_rd"}, o_rd, exp_rd);
    check({name, "_fault"}, 32'(o_fault), 32'd0);
    check({name, "_inst_rd"}, 32'(o_inst_rd), 32'(5'(tag) + 5'd3));
    check({name, "_pc_next"}, o_pc_next, 32'h1000 + {28'd0, tag} * 4);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    drive(v.tag, v.rd_en, v.wr_en, v.width, v.sgn, v.addr, v.rd);
    i_bus_rdata = v.rdata;
    step();
    if (!v.is_mem) begin
      check({nm, "_req"}, 32'(o_bus_request), 32'd0);
      check_result(nm, v.tag, v.exp_rd);
    end else begin
      check({nm, "_req"}, 32'(o_bus_request), 32'd1);
      check({nm, "_addr"}, o_bus_address, v.exp_addr);
      check({nm, "_be"}, 32'(o_bus_byte_enable), 32'(v.exp_be));
      check({nm, "_wdata"}, o_bus_wdata, v.exp_wdata);
      check({nm, "_rw"}, 32'(o_bus_rw), 32'(v.wr_en));
      check({nm, "_stall"}, 32'(o_stall), 32'd1);
      repeat (v.waits) step();
      check({nm, "_req_hold"}, 32'(o_bus_request), 32'd1);
      i_bus_ready = 1'b1;
      step();
      i_bus_ready = 1'b0;
      check({nm, "_req_done"}, 32'(o_bus_request), 32'd0);
      check({nm, "_tag_early"}, 32'(o_tag), 32'(4'(v.tag - 4'd1)));
      step();
      check_result(nm, v.tag, v.exp_rd);
    end
  endtask

  task automatic split_seq(input string nm, input logic [3:0] tag, input logic wr_en,
                           input logic [2:0] width, input logic sgn, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] rdata0,
                           input logic [31:0] rdata1, input logic [3:0] be0,
                           input logic [3:0] be1, input logic [31:0] wdata0,
                           input logic [31:0] wdata1, input logic [31:0] exp_rd);
    logic [31:0] base;
    base = {addr[31:2], 2'b00};
    drive(tag, !wr_en, wr_en, width, sgn, addr, rd);
    i_bus_rdata = rdata0;
    step();
    check({nm, "_addr0"}, o_bus_address, base);
    check({nm, "_be0"}, 32'(o_bus_byte_enable), 32'(be0));
    check({nm, "_wdata0"}, o_bus_wdata, wdata0);
    i_bus_ready = 1'b1;
    step();
    i_bus_rdata = rdata1;
    check({nm, "_req1"}, 32'(o_bus_request), 32'd1);
    check({nm, "_addr1"}, o_bus_address, base + 32'd4);
    check({nm, "_be1"}, 32'(o_bus_byte_enable), 32'(be1));
    check({nm, "_wdata1"}, o_bus_wdata, wdata1);
    step();
    i_bus_ready = 1'b0;
    check({nm, "_req_done"}, 32'(o_bus_request), 32'd0);
    step();
    check_result(nm, tag, exp_rd);
  endtask

  initial begin
    //          tag  mem rd wr width sgn addr          rd            rdata         w  exp_addr      be       wdata         exp_rd
    vecs[0] = '{4'd1,  0, 0, 0, 3'd0, 0, 32'h0,        32'hAAAA0001, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'hAAAA0001};
    vecs[1] = '{4'd2,  0, 0, 0, 3'd0, 0, 32'h0,        32'h00001234, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h00001234};
    vecs[2] = '{4'd3,  1, 1, 0, 3'd1, 1, 32'h103,      32'h0,        32'h80FFFFFF, 3, 32'h100,      4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[3] = '{4'd4,  1, 1, 0, 3'd1, 0, 32'h103,      32'h0,        32'h80FFFFFF, 0, 32'h100,      4'b1000, 32'h0,        32'h00000080};
    vecs[4] = '{4'd5,  1, 0, 1, 3'd2, 0, 32'h202,      32'hDEADBEEF, 32'h0,        1, 32'h200,      4'b1100, 32'hBEEF0000, 32'hDEADBEEF};
    vecs[5] = '{4'd6,  1, 1, 0, 3'd2, 0, 32'h102,      32'h0,        32'h80011234, 0, 32'h100,      4'b1100, 32'h0,        32'h00008001};
    vecs[6] = '{4'd7,  1, 1, 0, 3'd2, 1, 32'h101,      32'h0,        32'hAA8001BB, 0, 32'h100,      4'b0110, 32'h0,        32'hFFFF8001};
    vecs[7] = '{4'd8,  1, 1, 0, 3'd4, 0, 32'h300,      32'h0,        32'hCAFEF00D, 2, 32'h300,      4'b1111, 32'h0,        32'hCAFEF00D};
    vecs[8] = '{4'd9,  1, 0, 1, 3'd1, 0, 32'h001,      32'h000000A5, 32'h0,        0, 32'h000,      4'b0010, 32'h0000A500, 32'h000000A5};
    vecs[9] = '{4'd10, 0, 1, 0, 3'd3, 0, 32'h100,      32'h00005A5A, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h00005A5A};

    i_reset = 1'b0;
    i_stall = 1'b0;
    drive(4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    i_bus_rdata = 32'h0;
    repeat (3) step();
    check("rst_tag", 32'(o_tag), 32'd0);
    check("rst_rd", o_rd, 32'd0);
    check("rst_req", 32'(o_bus_request), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_be", 32'(o_bus_byte_enable), 32'd0);
    i_reset = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    split_seq("lw_split", 4'd11, 1'b0, 3'd4, 1'b0, 32'h101, 32'h0, 32'h44332211,
              32'h88776655, 4'b1110, 4'b0001, 32'h0, 32'h0, 32'h55443322);
    split_seq("sw_split", 4'd12, 1'b1, 3'd4, 1'b0, 32'h103, 32'hAABBCCDD, 32'h0,
              32'h0, 4'b1000, 4'b0111, 32'hDD000000, 32'h00AABBCC, 32'hAABBCCDD);
    split_seq("lh_split", 4'd13, 1'b0, 3'd2, 1'b1, 32'h0FF, 32'h0, 32'h7F000000,
              32'h000000FF, 4'b1000, 4'b0001, 32'h0, 32'h0, 32'hFFFFFF7F);

    // Stall in IDLE: the new tag must never be accepted.
    i_stall = 1'b1;
    drive(4'd14, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h99);
    repeat (4) step();
    check("stall_tag", 32'(o_tag), 32'd13);
    check("stall_req", 32'(o_bus_request), 32'd0);

    // Reset in the middle of a waiting access.
    i_stall = 1'b0;
    drive(4'd14, 1'b1, 1'b0, 3'd4, 1'b0, 32'h400, 32'h0);
    step();
    check("mid_req", 32'(o_bus_request), 32'd1);
    step();
    i_reset = 1'b0;
    #1;
    check("rstmid_req", 32'(o_bus_request), 32'd0);
    check("rstmid_tag", 32'(o_tag), 32'd0);
    check("rstmid_rd", o_rd, 32'd0);
    drive(4'd1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h002, 32'h0);
    step();
    i_reset = 1'b1;

    // No-split instance: misaligned word faults without touching the bus.
    step();
    check("ns_mis_req", 32'(n_bus_request), 32'd0);
    check("ns_mis_tag", 32'(n_tag), 32'd1);
    check("ns_mis_fault", 32'(n_fault), 32'd1);
    check("ns_mis_rd", n_rd, 32'd0);

    // Timeout: request held 4 cycles, then DONE with fault.
    drive(4'd2, 1'b1, 1'b0, 3'd4, 1'b0, 32'h100, 32'h0);
    step();
    check("to_req0", 32'(n_bus_request), 32'd1);
    repeat (3) step();
    check("to_req3", 32'(n_bus_request), 32'd1);
    check("to_stall", 32'(n_stall), 32'd1);
    step();
    check("to_req_drop", 32'(n_bus_request), 32'd0);
    check("to_tag_early", 32'(n_tag), 32'd1);
    step();
    check("to_tag", 32'(n_tag), 32'd2);
    check("to_fault", 32'(n_fault), 32'd1);
    check("to_rd", n_rd, 32'd0);

    drive(4'd3, 1'b1, 1'b0, 3'd2, 1'b1, 32'h101, 32'h0);
    step();
    check("ns_lh_tag", 32'(n_tag), 32'd3);
    check("ns_lh_fault", 32'(n_fault), 32'd1);

    drive(4'd4, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h77);
    step();
    check("ns_pass_fault", 32'(n_fault), 32'd0);
    check("ns_pass_rd", n_rd, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
